vend_ctrl: RTL

Vending controller that sits directly downstream of the denomination decoder. Consumes its 8-bit rupee value and its invalid-switch flag, accumulates credit one deposit at a time, and vends an item of fixed price on request. Returns change, or the full balance on cancel, one coin per cycle, always largest denomination first.

---
 rtl/vend_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates decoder deposits, vends at a fixed price, and
// returns change or the refund greedily, one coin per cycle, largest coin first.
module vend_ctrl #(
   parameter logic [7:0] PRICE = 8'd65
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] amount,
   input  logic       invalid,
   input  logic       buy,
   input  logic       cancel,
   output logic [7:0] balance,
   output logic       dispense,
   output logic       change_valid,
   output logic [7:0] change_coin,
   output logic       reject,
   output logic       busy
);

   // state  | meaning
   // IDLE   | no credit, balance == 0
   // CREDIT | credit held, balance > 0
   // VEND   | item released this cycle (one cycle)
   // CHANGE | returning balance one coin per cycle
   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   state_t     state, state_nxt;
   logic [7:0] balance_nxt;
   logic       reject_nxt;
   logic [7:0] amount_prev;
   logic       invalid_prev;
   logic       deposit;
   logic       invalid_edge;
   logic [8:0] sum;

   assign deposit      = (amount != 8'd0) && (amount_prev == 8'd0) && !invalid;
   assign invalid_edge = invalid && !invalid_prev;
   assign sum          = {1'b0, balance} + {1'b0, amount};

   assign dispense     = (state == VEND);
   assign change_valid = (state == CHANGE);
   assign busy         = dispense || change_valid;

   always_comb begin
      change_coin = 8'd0;
      if (state == CHANGE) begin
         if      (balance >= 8'd100) change_coin = 8'd100;
         else if (balance >= 8'd50)  change_coin = 8'd50;
         else if (balance >= 8'd20)  change_coin = 8'd20;
         else if (balance >= 8'd10)  change_coin = 8'd10;
         else if (balance >= 8'd5)   change_coin = 8'd5;
         else if (balance >= 8'd1)   change_coin = 8'd1;
      end
   end

   always_comb begin
      state_nxt   = state;
      balance_nxt = balance;
      reject_nxt  = 1'b0;
      case (state)
         IDLE, CREDIT: begin
            reject_nxt = invalid_edge;
            if (cancel && state == CREDIT) begin
               state_nxt  = CHANGE;
               reject_nxt = reject_nxt | deposit;
            end else if (buy && !cancel) begin
               // an accepted or refused buy both swallow a coincident deposit
               if (state == CREDIT && balance >= PRICE) begin
                  balance_nxt = balance - PRICE;
                  state_nxt   = VEND;
                  reject_nxt  = reject_nxt | deposit;
               end else begin
                  reject_nxt = 1'b1;
               end
            end else if (deposit) begin
               if (sum[8]) begin
                  reject_nxt = 1'b1;
               end else begin
                  balance_nxt = sum[7:0];
                  state_nxt   = CREDIT;
               end
            end
         end
         VEND: begin
            reject_nxt = deposit | buy | invalid_edge;
            state_nxt  = (balance != 8'd0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_nxt  = deposit | buy | invalid_edge;
            balance_nxt = balance - change_coin;
            if (balance == change_coin) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         balance      <= 8'd0;
         reject       <= 1'b0;
         amount_prev  <= 8'd0;
         invalid_prev <= 1'b0;
      end else begin
         state        <= state_nxt;
         balance      <= balance_nxt;
         reject       <= reject_nxt;
         amount_prev  <= amount;
         invalid_prev <= invalid;
      end
   end

endmodule
